// File: rtl/core_id_regfile_mp.sv
// ID-stage integer register file: NRD read / NWR write ports,
// optional writeback bypass, and a pending-write busy scoreboard.
module core_id_regfile_mp #(
  parameter int XLEN     = 32,
  parameter int RF_NUM   = 32,
  parameter int IDX_W    = 5,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NRD*IDX_W-1:0]  rd_idx,
  output logic [NRD*XLEN-1:0]   rd_dat,
  output logic [NRD-1:0]        rd_busy,
  input  logic [NWR-1:0]        wb_wen,
  input  logic [NWR*IDX_W-1:0]  wb_idx,
  input  logic [NWR*XLEN-1:0]   wb_dat,
  input  logic                  iss_vld,
  input  logic [IDX_W-1:0]      iss_idx,
  output logic                  iss_rdy,
  input  logic                  flush
);

  logic [XLEN-1:0]   regs_q [RF_NUM];
  logic [XLEN-1:0]   regs_d [RF_NUM];
  logic [RF_NUM-1:0] busy_q;
  logic [RF_NUM-1:0] busy_d;

  function automatic logic idx_ok(input logic [IDX_W-1:0] idx);
    idx_ok = (32'(idx) < 32'(RF_NUM)) &&
             !((ZERO_REG != 0) && (idx == '0));
  endfunction

  always_comb begin
    iss_rdy = 1'b1;
    for (int i = 0; i < RF_NUM; i++)
      if (iss_idx == IDX_W'(i))
        iss_rdy = ~busy_q[i];
  end

  // Ascending port order makes the highest writing port win.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    for (int j = 0; j < NWR; j++) begin
      if (wb_wen[j] && idx_ok(wb_idx[j*IDX_W +: IDX_W])) begin
        for (int i = 0; i < RF_NUM; i++) begin
          if (wb_idx[j*IDX_W +: IDX_W] == IDX_W'(i)) begin
            regs_d[i] = wb_dat[j*XLEN +: XLEN];
            busy_d[i] = 1'b0;
          end
        end
      end
    end
    if (flush) begin
      busy_d = '0;
    end else if (iss_vld && iss_rdy && idx_ok(iss_idx)) begin
      for (int i = 0; i < RF_NUM; i++)
        if (iss_idx == IDX_W'(i))
          busy_d[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RF_NUM; i++)
        regs_q[i] <= '0;
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [IDX_W-1:0] ridx;
    logic             hit;
    logic [XLEN-1:0]  byp;
    logic [XLEN-1:0]  stored;
    logic             bsy;

    assign ridx = rd_idx[k*IDX_W +: IDX_W];

    always_comb begin
      hit    = 1'b0;
      byp    = '0;
      stored = '0;
      bsy    = 1'b0;
      if (BYPASS != 0) begin
        for (int j = 0; j < NWR; j++) begin
          if (wb_wen[j] && wb_idx[j*IDX_W +: IDX_W] == ridx) begin
            hit = 1'b1;
            byp = wb_dat[j*XLEN +: XLEN];
          end
        end
      end
      for (int i = 0; i < RF_NUM; i++) begin
        if (ridx == IDX_W'(i)) begin
          stored = regs_q[i];
          bsy    = busy_q[i];
        end
      end
      if (!idx_ok(ridx)) begin
        hit    = 1'b0;
        stored = '0;
        bsy    = 1'b0;
      end
    end

    assign rd_dat[k*XLEN +: XLEN] = hit ? byp : stored;
    assign rd_busy[k]             = bsy & ~hit;
  end

endmodule
